// File: rtl/code_loader.sv
// Frames a UART byte stream (HEADER, N, 4*N data bytes, XOR checksum) into
// 32-bit instruction words and writes them to code memory at addresses 0,4,8...
module code_loader #(
  parameter int         DEPTH  = 32,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        loaded_o,
  output logic        error_o,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [8:0] MAX_N = 9'(DEPTH);

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  // Lanes 0..2 of the word being assembled; lane 3 comes straight from rx_data_i.
  logic [23:0] word_q, word_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        loaded_q, loaded_d;
  logic        error_q, error_d;

  logic is_header;
  assign is_header = (rx_data_i == HEADER);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      loaded_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      csum_q      <= csum_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      loaded_q    <= loaded_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    csum_d      = csum_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    loaded_d    = loaded_q;
    error_d     = error_q;

    if (rx_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (is_header) begin
            state_d  = S_COUNT;
            error_d  = 1'b0;
            loaded_d = 1'b0;
          end
        end
        S_COUNT: begin
          if (rx_data_i == 8'd0 || {1'b0, rx_data_i} > MAX_N) begin
            state_d  = S_ERR;
            error_d  = 1'b1;
            loaded_d = 1'b0;
          end else begin
            count_d    = rx_data_i;
            word_idx_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
            state_d    = S_DATA;
          end
        end
        S_DATA: begin
          // HEADER-valued bytes here are plain data; only the byte count ends the frame.
          csum_d     = csum_q ^ rx_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = rx_data_i;
            2'd1: word_d[15:8]  = rx_data_i;
            2'd2: word_d[23:16] = rx_data_i;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = {22'd0, word_idx_q, 2'b00};
              mem_wdata_d = {rx_data_i, word_q};
              if (word_idx_q == count_q - 8'd1) begin
                state_d = S_CSUM;
              end else begin
                word_idx_d = word_idx_q + 8'd1;
              end
            end
          endcase
        end
        S_CSUM: begin
          if (rx_data_i == csum_q) begin
            state_d  = S_DONE;
            loaded_d = 1'b1;
          end else begin
            state_d  = S_ERR;
            error_d  = 1'b1;
            loaded_d = 1'b0;
          end
        end
        S_DONE: begin
          if (is_header) begin
            state_d  = S_COUNT;
            loaded_d = 1'b0;
            error_d  = 1'b0;
          end
        end
        S_ERR: begin
          if (is_header) begin
            state_d  = S_COUNT;
            error_d  = 1'b0;
            loaded_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign loaded_o    = loaded_q;
  assign error_o     = error_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_code_loader.sv
// Randomized frame stimulus for code_loader; expected memory writes are queued
// from a byte-level frame model and matched by an independent write monitor.
module tb_code_loader;

  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        loaded;
  logic        error;
  logic [2:0]  state_dbg;

  code_loader #(.DEPTH(32), .HEADER(8'hA5)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .loaded_o    (loaded),
    .error_o     (error),
    .state_dbg_o (state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] preset_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest expected write,
  // in the cycle right after the strobe that carried the word's last byte.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'(mem_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
          check("wr_cycle", 32'(cyc), 32'(e.due));
          $display("write addr=%h data=%h cycle=%0d", mem_addr, mem_wdata, cyc);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [2:0] st, input logic ld, input logic er);
    @(negedge clk);
    check({tag, "_state"}, 32'(state_dbg), 32'(st));
    check({tag, "_loaded"}, 32'(loaded), 32'(ld));
    check({tag, "_error"}, 32'(error), 32'(er));
    @(posedge clk);
    #1;
  endtask

  // Sends one whole frame; data comes from preset_q when it is loaded,
  // otherwise random. Expected writes are derived from the byte list.
  task automatic send_frame(input int n, input bit bad_csum, input bit force_a5, input int maxgap);
    logic [7:0] bytes[$];
    logic [7:0] b;
    logic [7:0] cs;
    wr_t        w;
    $display("frame n=%0d bad_csum=%0d a5=%0d maxgap=%0d", n, bad_csum, force_a5, maxgap);
    send_byte(HDR, $urandom_range(maxgap, 0));
    check_status("hdr", 3'd1, 1'b0, 1'b0);
    send_byte(8'(n), $urandom_range(maxgap, 0));
    if (n == 0 || n > 32) begin
      check_status("badcount", 3'd5, 1'b0, 1'b1);
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      if (preset_q.size() > 0) b = preset_q.pop_front();
      else b = 8'($urandom);
      if (force_a5 && i == 1) b = HDR;
      cs ^= b;
      bytes.push_back(b);
      send_byte(b, $urandom_range(maxgap, 0));
      if (i % 4 == 3) begin
        w.addr = 32'(4 * (i / 4));
        w.data = {bytes[i], bytes[i-1], bytes[i-2], bytes[i-3]};
        w.due  = cyc;
        exp_q.push_back(w);
      end
    end
    check_status("precsum", 3'd3, 1'b0, 1'b0);
    send_byte(bad_csum ? cs + 8'd1 : cs, $urandom_range(maxgap, 0));
    if (bad_csum) check_status("csum_bad", 3'd5, 1'b0, 1'b1);
    else          check_status("csum_ok", 3'd4, 1'b1, 1'b0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rx_valid = 1'b0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;

    // Garbage before a header is ignored.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    check_status("garbage", 3'd0, 1'b0, 1'b0);

    // Known single-word image.
    preset_q = '{8'h13, 8'h00, 8'hA0, 8'hE3};
    send_frame(1, 1'b0, 1'b0, 0);
    check("t1_wdata", mem_wdata, 32'hE3A00013);
    check("t1_addr", mem_addr, 32'h0);

    // Two-word frames with different inter-byte gaps.
    send_frame(2, 1'b0, 1'b0, 0);
    send_frame(2, 1'b0, 1'b0, 5);

    // Bad checksum, then recovery.
    send_frame(2, 1'b1, 1'b0, 2);
    send_frame(2, 1'b0, 1'b0, 1);

    // Count boundaries.
    send_frame(0, 1'b0, 1'b0, 1);
    send_frame(33, 1'b0, 1'b0, 1);
    send_frame(32, 1'b0, 1'b0, 0);
    check("last_addr_7c", mem_addr, 32'h7C);

    // Header value inside data is not a restart.
    send_frame(3, 1'b0, 1'b1, 2);

    // Reset mid-frame after second data byte.
    send_byte(HDR, 0);
    check_status("reload_hdr", 3'd1, 1'b0, 1'b0);
    send_byte(8'd2, 0);
    send_byte(8'($urandom), 1);
    send_byte(8'($urandom), 0);
    pulse_reset();
    @(negedge clk);
    check("midrst_state", 32'(state_dbg), 32'd0);
    check("midrst_loaded", 32'(loaded), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    send_frame(3, 1'b0, 1'b0, 1);
    send_frame(2, 1'b0, 1'b0, 3);

    // Random mix.
    for (int k = 0; k < 10; k++) begin
      send_frame($urandom_range(8, 1), ($urandom_range(3, 0) == 0), 1'b0, $urandom_range(5, 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
